// File: rtl/mem_access.sv
// mem_access: load/store unit between EX and the MEM/WB register; runs one req/ack data-bus access per MEM_OP.
// Latency: 1 IDLE cycle + N BUSY cycles until ack (or TIMEOUT abort) + 1 DONE cycle with the result on o_mem_read.
// Backpressure: o_stall holds the pipeline from op issue until the access ends; DONE is the release cycle.
//
// Ports: clk/clr (async active-high); i_mem_op/i_addr/i_wr_data from EX; o_mem_read/o_stall/o_err to pipeline;
//        o_bus_req/o_bus_we/o_bus_addr/o_bus_wdata/o_bus_be and i_bus_ack/i_bus_rdata form the data-memory bus.
// Optional: define MEM_ACCESS_MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning them down.

`ifndef MEM_ACCESS_DEFS
`define MEM_ACCESS_DEFS
`define WORD_W          32
`define ADDR_W          32
`define MEM_OP_W        4
`define MEM_OP_NONE     4'd0
`define MEM_OP_RD_BYTE  4'd1
`define MEM_OP_RD_UBYTE 4'd2
`define MEM_OP_RD_HALF  4'd3
`define MEM_OP_RD_UHALF 4'd4
`define MEM_OP_RD_WORD  4'd5
`define MEM_OP_WR_BYTE  4'd6
`define MEM_OP_WR_HALF  4'd7
`define MEM_OP_WR_WORD  4'd8
`endif

module mem_access #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [`MEM_OP_W-1:0] i_mem_op,
  input  logic [`ADDR_W-1:0]   i_addr,
  input  logic [`WORD_W-1:0]   i_wr_data,
  output logic [`WORD_W-1:0]   o_mem_read,
  output logic                 o_stall,
  output logic                 o_err,
  output logic                 o_bus_req,
  output logic                 o_bus_we,
  output logic [`ADDR_W-1:0]   o_bus_addr,
  output logic [`WORD_W-1:0]   o_bus_wdata,
  output logic [3:0]           o_bus_be,
  input  logic                 i_bus_ack,
  input  logic [`WORD_W-1:0]   i_bus_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state, state_nxt;
  logic [`MEM_OP_W-1:0] op_q, op_nxt;
  logic [1:0]           lo_q, lo_nxt;
  logic [CW-1:0]        cnt_q, cnt_nxt;
  logic                 req_nxt, we_nxt, err_nxt;
  logic [`ADDR_W-1:0]   addr_nxt;
  logic [`WORD_W-1:0]   wdata_nxt, rd_nxt;
  logic [3:0]           be_nxt;

  // Decode of the incoming op
  logic       in_byte, in_half, in_word, in_store, misalign;
  logic [1:0] in_lo;

  always_comb begin
    in_byte  = (i_mem_op == `MEM_OP_RD_BYTE) || (i_mem_op == `MEM_OP_RD_UBYTE) ||
               (i_mem_op == `MEM_OP_WR_BYTE);
    in_half  = (i_mem_op == `MEM_OP_RD_HALF) || (i_mem_op == `MEM_OP_RD_UHALF) ||
               (i_mem_op == `MEM_OP_WR_HALF);
    in_word  = (i_mem_op == `MEM_OP_RD_WORD) || (i_mem_op == `MEM_OP_WR_WORD);
    in_store = (i_mem_op == `MEM_OP_WR_BYTE) || (i_mem_op == `MEM_OP_WR_HALF) ||
               (i_mem_op == `MEM_OP_WR_WORD);
    misalign = (in_half && i_addr[0]) || (in_word && (i_addr[1:0] != 2'b00));
    // Offset within the word after aligning down to the access size
    in_lo    = in_word ? 2'b00 : (in_half ? {i_addr[1], 1'b0} : i_addr[1:0]);
  end

  // Lane extraction and extension, driven by the latched op/offset
  logic [7:0]         lane_b;
  logic [15:0]        lane_h;
  logic [`WORD_W-1:0] ext;

  always_comb begin
    case (lo_q)
      2'd0:    lane_b = i_bus_rdata[7:0];
      2'd1:    lane_b = i_bus_rdata[15:8];
      2'd2:    lane_b = i_bus_rdata[23:16];
      default: lane_b = i_bus_rdata[31:24];
    endcase
    lane_h = lo_q[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];
    case (op_q)
      `MEM_OP_RD_BYTE:  ext = {{24{lane_b[7]}}, lane_b};
      `MEM_OP_RD_UBYTE: ext = {24'h0, lane_b};
      `MEM_OP_RD_HALF:  ext = {{16{lane_h[15]}}, lane_h};
      `MEM_OP_RD_UHALF: ext = {16'h0, lane_h};
      `MEM_OP_RD_WORD:  ext = i_bus_rdata;
      default:          ext = '0;  // stores return 0
    endcase
  end

  // Stall in IDLE only while an op is pending, so DONE is the release cycle
  assign o_stall = ((state == IDLE) && (i_mem_op != `MEM_OP_NONE)) || (state == BUSY);

  always_comb begin
    state_nxt = state;
    op_nxt    = op_q;
    lo_nxt    = lo_q;
    cnt_nxt   = cnt_q;
    req_nxt   = o_bus_req;
    we_nxt    = o_bus_we;
    err_nxt   = o_err;
    addr_nxt  = o_bus_addr;
    wdata_nxt = o_bus_wdata;
    be_nxt    = o_bus_be;
    rd_nxt    = o_mem_read;
    case (state)
      IDLE: begin
        if (i_mem_op != `MEM_OP_NONE) begin
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
          if (misalign) begin
            state_nxt = DONE;
            err_nxt   = 1'b1;
            rd_nxt    = '0;
          end else begin
`else
          begin
`endif
            state_nxt = BUSY;
            op_nxt    = i_mem_op;
            lo_nxt    = in_lo;
            cnt_nxt   = '0;
            req_nxt   = 1'b1;
            we_nxt    = in_store;
            addr_nxt  = {i_addr[`ADDR_W-1:2], 2'b00};
            if (!in_store) begin
              be_nxt    = 4'hF;
              wdata_nxt = '0;
            end else if (in_byte) begin
              be_nxt    = 4'b0001 << in_lo;
              wdata_nxt = {4{i_wr_data[7:0]}};
            end else if (in_half) begin
              be_nxt    = in_lo[1] ? 4'b1100 : 4'b0011;
              wdata_nxt = {2{i_wr_data[15:0]}};
            end else begin
              be_nxt    = 4'hF;
              wdata_nxt = i_wr_data;
            end
          end
        end
      end
      BUSY: begin
        if (i_bus_ack) begin
          rd_nxt    = ext;
          req_nxt   = 1'b0;
          state_nxt = DONE;
        end else if (cnt_q == CNT_LAST) begin
          rd_nxt    = '0;
          req_nxt   = 1'b0;
          err_nxt   = 1'b1;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt_q + CW'(1);
        end
      end
      DONE: begin
        err_nxt   = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state       <= IDLE;
      op_q        <= `MEM_OP_NONE;
      lo_q        <= 2'b00;
      cnt_q       <= '0;
      o_bus_req   <= 1'b0;
      o_bus_we    <= 1'b0;
      o_err       <= 1'b0;
      o_bus_addr  <= '0;
      o_bus_wdata <= '0;
      o_bus_be    <= 4'h0;
      o_mem_read  <= '0;
    end else begin
      state       <= state_nxt;
      op_q        <= op_nxt;
      lo_q        <= lo_nxt;
      cnt_q       <= cnt_nxt;
      o_bus_req   <= req_nxt;
      o_bus_we    <= we_nxt;
      o_err       <= err_nxt;
      o_bus_addr  <= addr_nxt;
      o_bus_wdata <= wdata_nxt;
      o_bus_be    <= be_nxt;
      o_mem_read  <= rd_nxt;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: scoreboard bench for mem_access with TIMEOUT=4.
// Driver issues ops and pushes expected results; a monitor pops them when the stall releases (DONE).
// A bus slave process answers requests after a per-op number of BUSY cycles (0 = never).

`ifndef MEM_ACCESS_DEFS
`define MEM_ACCESS_DEFS
`define WORD_W          32
`define ADDR_W          32
`define MEM_OP_W        4
`define MEM_OP_NONE     4'd0
`define MEM_OP_RD_BYTE  4'd1
`define MEM_OP_RD_UBYTE 4'd2
`define MEM_OP_RD_HALF  4'd3
`define MEM_OP_RD_UHALF 4'd4
`define MEM_OP_RD_WORD  4'd5
`define MEM_OP_WR_BYTE  4'd6
`define MEM_OP_WR_HALF  4'd7
`define MEM_OP_WR_WORD  4'd8
`endif

module tb_mem_access;

  logic                 clk = 1'b0;
  logic                 clr;
  logic [`MEM_OP_W-1:0] i_mem_op;
  logic [`ADDR_W-1:0]   i_addr;
  logic [`WORD_W-1:0]   i_wr_data;
  logic [`WORD_W-1:0]   o_mem_read;
  logic                 o_stall, o_err, o_bus_req, o_bus_we;
  logic [`ADDR_W-1:0]   o_bus_addr;
  logic [`WORD_W-1:0]   o_bus_wdata;
  logic [3:0]           o_bus_be;
  logic                 i_bus_ack;
  logic [`WORD_W-1:0]   i_bus_rdata;

  mem_access #(.TIMEOUT(4)) dut (
    .clk(clk), .clr(clr), .i_mem_op(i_mem_op), .i_addr(i_addr), .i_wr_data(i_wr_data),
    .o_mem_read(o_mem_read), .o_stall(o_stall), .o_err(o_err), .o_bus_req(o_bus_req),
    .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr), .o_bus_wdata(o_bus_wdata), .o_bus_be(o_bus_be),
    .i_bus_ack(i_bus_ack), .i_bus_rdata(i_bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] mem_read;
    logic        err;
    int          stall_cyc;
    int          req_cyc;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  int          ack_delay = 0;
  logic [31:0] slave_rdata = 32'h0;
  logic        late_ack = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input string nm, input logic [31:0] rd, input logic err,
                              input int stall_c, input int req_c, input logic we,
                              input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
    exp_t e;
    e.name = nm; e.mem_read = rd; e.err = err; e.stall_cyc = stall_c; e.req_cyc = req_c;
    e.we = we; e.addr = addr; e.be = be; e.wdata = wd;
    return e;
  endfunction

  // Called at posedge+1 with the DUT in IDLE; returns at posedge+1 after DONE with op back to NONE.
  task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                       input int dly, input logic [31:0] rd, input exp_t e);
    bit released;
    exp_q.push_back(e);
    ack_delay   = dly;
    slave_rdata = rd;
    i_mem_op    = op;
    i_addr      = addr;
    i_wr_data   = wd;
    released    = 1'b0;
    for (int i = 0; i < 40 && !released; i++) begin
      @(negedge clk);
      if (!o_stall) released = 1'b1;
    end
    if (!released) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s: stall never released within 40 cycles", e.name);
    end
    @(posedge clk);
    #1;
    i_mem_op = `MEM_OP_NONE;
  endtask

  // Bus slave
  initial begin
    int scnt;
    scnt = 0;
    i_bus_ack = 1'b0;
    i_bus_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (clr) begin
        scnt = 0;
        i_bus_ack = 1'b0;
      end else if (o_bus_req) begin
        scnt++;
        i_bus_ack   = (ack_delay != 0) && (scnt == ack_delay);
        i_bus_rdata = i_bus_ack ? slave_rdata : 32'h0;
      end else begin
        scnt = 0;
        i_bus_ack   = late_ack;
        i_bus_rdata = late_ack ? 32'h12345678 : 32'h0;
      end
    end
  end

  // Monitor: pops an expectation whenever the stall releases into DONE
  initial begin
    logic        prev_stall, prev_req, cap_we;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    int          stall_cnt, req_cnt;
    exp_t        e;
    prev_stall = 1'b0; prev_req = 1'b0; stall_cnt = 0; req_cnt = 0;
    cap_we = 1'b0; cap_addr = 32'h0; cap_wdata = 32'h0; cap_be = 4'h0;
    forever begin
      @(negedge clk);
      if (clr) begin
        prev_stall = 1'b0; prev_req = 1'b0; stall_cnt = 0; req_cnt = 0;
      end else begin
        if (o_bus_req && !prev_req) begin
          cap_we = o_bus_we; cap_addr = o_bus_addr; cap_wdata = o_bus_wdata; cap_be = o_bus_be;
        end
        if (o_bus_req) req_cnt++;
        if (o_stall) stall_cnt++;
        if (prev_stall && !o_stall) begin
          if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL unexpected_done: got completion, expected none pending");
          end else begin
            e = exp_q.pop_front();
            check({e.name, ".mem_read"}, o_mem_read, e.mem_read);
            check({e.name, ".err"}, {31'h0, o_err}, {31'h0, e.err});
            check({e.name, ".stall_cycles"}, stall_cnt, e.stall_cyc);
            check({e.name, ".req_cycles"}, req_cnt, e.req_cyc);
            if (e.req_cyc > 0) begin
              check({e.name, ".we"}, {31'h0, cap_we}, {31'h0, e.we});
              check({e.name, ".addr"}, cap_addr, e.addr);
              check({e.name, ".be"}, {28'h0, cap_be}, {28'h0, e.be});
              if (e.we) check({e.name, ".wdata"}, cap_wdata, e.wdata);
            end
          end
          stall_cnt = 0;
          req_cnt = 0;
        end
        prev_stall = o_stall;
        prev_req = o_bus_req;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clr = 1'b1;
    i_mem_op = `MEM_OP_NONE;
    i_addr = 32'h0;
    i_wr_data = 32'h0;
    repeat (2) @(negedge clk);
    check("rst.bus_req", {31'h0, o_bus_req}, 32'h0);
    check("rst.bus_we", {31'h0, o_bus_we}, 32'h0);
    check("rst.err", {31'h0, o_err}, 32'h0);
    check("rst.stall", {31'h0, o_stall}, 32'h0);
    check("rst.bus_addr", o_bus_addr, 32'h0);
    check("rst.bus_wdata", o_bus_wdata, 32'h0);
    check("rst.bus_be", {28'h0, o_bus_be}, 32'h0);
    check("rst.mem_read", o_mem_read, 32'h0);
    @(posedge clk);
    #1;
    clr = 1'b0;

    issue(`MEM_OP_RD_WORD, 32'h100, 32'h0, 3, 32'hDEADBEEF,
          mk("rd_word", 32'hDEADBEEF, 1'b0, 4, 3, 1'b0, 32'h100, 4'hF, 32'h0));
    issue(`MEM_OP_RD_BYTE, 32'h203, 32'h0, 1, 32'h80FF7F01,
          mk("rd_byte", 32'hFFFFFF80, 1'b0, 2, 1, 1'b0, 32'h200, 4'hF, 32'h0));
    issue(`MEM_OP_RD_UBYTE, 32'h203, 32'h0, 1, 32'h80FF7F01,
          mk("rd_ubyte", 32'h00000080, 1'b0, 2, 1, 1'b0, 32'h200, 4'hF, 32'h0));
    issue(`MEM_OP_RD_HALF, 32'h202, 32'h0, 1, 32'h80FF7F01,
          mk("rd_half", 32'hFFFF80FF, 1'b0, 2, 1, 1'b0, 32'h200, 4'hF, 32'h0));
    issue(`MEM_OP_RD_UHALF, 32'h200, 32'h0, 1, 32'h80FF7F01,
          mk("rd_uhalf", 32'h00007F01, 1'b0, 2, 1, 1'b0, 32'h200, 4'hF, 32'h0));
    issue(`MEM_OP_WR_BYTE, 32'h301, 32'h123456AB, 2, 32'h55555555,
          mk("wr_byte", 32'h0, 1'b0, 3, 2, 1'b1, 32'h300, 4'b0010, 32'hABABABAB));
    issue(`MEM_OP_WR_HALF, 32'h302, 32'h0000CAFE, 1, 32'h55555555,
          mk("wr_half_hi", 32'h0, 1'b0, 2, 1, 1'b1, 32'h300, 4'b1100, 32'hCAFECAFE));
    issue(`MEM_OP_WR_HALF, 32'h300, 32'h0000BEEF, 1, 32'h55555555,
          mk("wr_half_lo", 32'h0, 1'b0, 2, 1, 1'b1, 32'h300, 4'b0011, 32'hBEEFBEEF));
    issue(`MEM_OP_WR_WORD, 32'h404, 32'h01234567, 1, 32'h55555555,
          mk("wr_word", 32'h0, 1'b0, 2, 1, 1'b1, 32'h404, 4'hF, 32'h01234567));

    // Timeout: no ack, 4 BUSY cycles, then a late ack that must be ignored
    issue(`MEM_OP_RD_WORD, 32'h500, 32'h0, 0, 32'hFFFFFFFF,
          mk("timeout", 32'h0, 1'b1, 5, 4, 1'b0, 32'h500, 4'hF, 32'h0));
    check("timeout.err_clears", {31'h0, o_err}, 32'h0);
    @(posedge clk);
    #1;
    late_ack = 1'b1;
    @(posedge clk);
    #1;
    late_ack = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("late_ack.stall", {31'h0, o_stall}, 32'h0);
      check("late_ack.bus_req", {31'h0, o_bus_req}, 32'h0);
      check("late_ack.err", {31'h0, o_err}, 32'h0);
      check("late_ack.mem_read", o_mem_read, 32'h0);
    end
    @(posedge clk);
    #1;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    issue(`MEM_OP_RD_WORD, 32'h403, 32'h0, 1, 32'h11223344,
          mk("misalign_trap", 32'h0, 1'b1, 1, 0, 1'b0, 32'h0, 4'h0, 32'h0));
`else
    issue(`MEM_OP_RD_WORD, 32'h403, 32'h0, 1, 32'h11223344,
          mk("misalign_align", 32'h11223344, 1'b0, 2, 1, 1'b0, 32'h400, 4'hF, 32'h0));
`endif

    // Reset in the middle of BUSY
    ack_delay = 0;
    i_mem_op  = `MEM_OP_RD_WORD;
    i_addr    = 32'h600;
    @(posedge clk);
    #2;
    clr = 1'b1;
    i_mem_op = `MEM_OP_NONE;
    #1;
    check("clr.bus_req", {31'h0, o_bus_req}, 32'h0);
    check("clr.stall", {31'h0, o_stall}, 32'h0);
    check("clr.err", {31'h0, o_err}, 32'h0);
    check("clr.mem_read", o_mem_read, 32'h0);
    check("clr.bus_addr", o_bus_addr, 32'h0);
    check("clr.bus_be", {28'h0, o_bus_be}, 32'h0);
    @(posedge clk);
    #1;
    clr = 1'b0;
    @(posedge clk);
    #1;
    issue(`MEM_OP_RD_WORD, 32'h700, 32'h0, 1, 32'hA5A50F0F,
          mk("after_clr", 32'hA5A50F0F, 1'b0, 2, 1, 1'b0, 32'h700, 4'hF, 32'h0));

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
